uart_rx_deserializer: RTL and testbench

//  Serial receive path consuming the 16x oversample tick (baud_clock) from the baud generator.

---
 rtl/uart_rx_deserializer_pkg.sv | 30 +++
 rtl/uart_rx_deserializer_if.sv | 30 +++
 rtl/uart_rx_deserializer_bit_sampler.sv | 76 +++++++
 rtl/uart_rx_deserializer.sv | 148 ++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_deserializer_pkg.sv
// rtl/uart_rx_deserializer_pkg.sv - shared UART RX definitions (package uart_defs)
// Sample point follows UART_RX_MAJORITY_EN: 8 with majority voting, 7 otherwise.
package uart_defs;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_MAX   = 8;
  localparam int CNT_W      = $clog2(OVERSAMPLE);
  localparam int BCNT_W     = $clog2(DATA_MAX + 1);

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] SP = CNT_W'(8);
`else
  localparam logic [CNT_W-1:0] SP = CNT_W'(7);
`endif

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// rtl/uart_rx_deserializer_if.sv - host-side byte handshake of the UART receiver
// master = register layer consuming bytes, slave = receiver presenting them.
interface uart_rx_deserializer_if;

  logic       read_rx_byte;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       parity_err;
  logic       framing_err;
  logic       overflow;

  modport master (
    output read_rx_byte,
    input  rx_data,
    input  rx_ready,
    input  parity_err,
    input  framing_err,
    input  overflow
  );

  modport slave (
    input  read_rx_byte,
    output rx_data,
    output rx_ready,
    output parity_err,
    output framing_err,
    output overflow
  );

endinterface

// File: rtl/uart_rx_deserializer_bit_sampler.sv
// rtl/uart_rx_deserializer_bit_sampler.sv - rx_in synchroniser, 16x sample counter, bit decision
// UART_RX_MAJORITY_EN selects 3-tap majority voting around the sample point.
module uart_rx_bit_sampler
  import uart_defs::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic baud_clock,
  input  logic rx_in,
  input  logic run,
  output logic rx_sync,
  output logic bit_valid,
  output logic bit_value,
  output logic bit_end
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   tick_run;

  assign rx_sync  = sync_q[SYNC_STAGES-1];
  assign tick_run = run & baud_clock;

  // Counter is held at zero while idle so the detecting tick becomes count 0.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx_in};
    cnt_d  = cnt_q;
    if (!run) begin
      cnt_d = '0;
    end else if (baud_clock) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign bit_valid = tick_run & (cnt_q == SP);
  assign bit_end   = tick_run & (cnt_q == CNT_LAST);

`ifdef UART_RX_MAJORITY_EN
  logic early_q, early_d;
  logic mid_q, mid_d;

  always_comb begin
    early_d = early_q;
    mid_d   = mid_q;
    if (tick_run && (cnt_q == SP - CNT_W'(2))) early_d = rx_sync;
    if (tick_run && (cnt_q == SP - CNT_W'(1))) mid_d   = rx_sync;
  end

  assign bit_value = majority3(early_q, mid_q, rx_sync);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      early_q <= 1'b1;
      mid_q   <= 1'b1;
    end else begin
      early_q <= early_d;
      mid_q   <= mid_d;
    end
  end
`else
  assign bit_value = rx_sync;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - UART receive FSM, shift register, parity/stop check, host handshake
// Sample point and bit voting depend on UART_RX_MAJORITY_EN (see uart_rx_bit_sampler).
module uart_rx_deserializer
  import uart_defs::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   baud_clock,
  input  logic                   rx_in,
  input  logic                   bit8,
  input  logic                   parity_en,
  input  logic                   odd_n_even,
  uart_rx_deserializer_if.slave  host
);

  rx_state_e         state_q, state_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic              frame_perr_q, frame_perr_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              rx_ready_q, rx_ready_d;
  logic              parity_err_q, parity_err_d;
  logic              framing_err_q, framing_err_d;
  logic              overflow_q, overflow_d;

  logic              rx_sync;
  logic              bit_valid;
  logic              bit_value;
  logic              bit_end;
  logic              run;
  logic [BCNT_W-1:0] nbits;
  logic [7:0]        data_mask;

  assign run       = (state_q != IDLE);
  assign nbits     = bit8 ? BCNT_W'(DATA_MAX) : BCNT_W'(DATA_MAX - 1);
  assign data_mask = {bit8, 7'h7f};

  uart_rx_bit_sampler #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sampler (
    .clk        (clk),
    .reset_n    (reset_n),
    .baud_clock (baud_clock),
    .rx_in      (rx_in),
    .run        (run),
    .rx_sync    (rx_sync),
    .bit_valid  (bit_valid),
    .bit_value  (bit_value),
    .bit_end    (bit_end)
  );

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    frame_perr_d  = frame_perr_q;
    rx_data_d     = rx_data_q;
    rx_ready_d    = rx_ready_q;
    parity_err_d  = parity_err_q;
    framing_err_d = 1'b0;
    overflow_d    = 1'b0;

    // A plain read drops the byte; a completion in the same cycle overrides below.
    if (host.read_rx_byte) begin
      rx_ready_d   = 1'b0;
      parity_err_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (baud_clock && !rx_sync) state_d = START;
      end
      START: begin
        if (bit_valid && bit_value) begin
          state_d = IDLE;
        end else if (bit_end) begin
          state_d      = DATA;
          bit_cnt_d    = '0;
          shreg_d      = '0;
          frame_perr_d = 1'b0;
        end
      end
      DATA: begin
        if (bit_valid) begin
          shreg_d[bit_cnt_q[2:0]] = bit_value;
          bit_cnt_d               = bit_cnt_q + 1'b1;
        end else if (bit_end && (bit_cnt_q == nbits)) begin
          state_d = parity_en ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_valid) begin
          frame_perr_d = (^(shreg_q & data_mask)) ^ bit_value ^ odd_n_even;
        end else if (bit_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        // Return to idle mid stop bit so the next start edge is never missed.
        if (bit_valid) begin
          state_d       = IDLE;
          framing_err_d = ~bit_value;
          if (!rx_ready_q || host.read_rx_byte) begin
            rx_data_d    = shreg_q & data_mask;
            parity_err_d = frame_perr_q & parity_en;
            rx_ready_d   = 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      frame_perr_q  <= 1'b0;
      rx_data_q     <= '0;
      rx_ready_q    <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      frame_perr_q  <= frame_perr_d;
      rx_data_q     <= rx_data_d;
      rx_ready_q    <= rx_ready_d;
      parity_err_q  <= parity_err_d;
      framing_err_q <= framing_err_d;
      overflow_q    <= overflow_d;
    end
  end

  assign host.rx_data     = rx_data_q;
  assign host.rx_ready    = rx_ready_q;
  assign host.parity_err  = parity_err_q;
  assign host.framing_err = framing_err_q;
  assign host.overflow    = overflow_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb/tb_uart_rx_deserializer.sv - randomized self-checking bench for uart_rx_deserializer
module tb_uart_rx_deserializer;

`ifdef UART_RX_MAJORITY_EN
  localparam int SP = 8;
`else
  localparam int SP = 7;
`endif

  logic clk;
  logic reset_n;
  logic baud_clock;
  logic rx_in;
  logic bit8;
  logic parity_en;
  logic odd_n_even;

  uart_rx_deserializer_if u_if ();

  uart_rx_deserializer #(
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .baud_clock (baud_clock),
    .rx_in      (rx_in),
    .bit8       (bit8),
    .parity_en  (parity_en),
    .odd_n_even (odd_n_even),
    .host       (u_if.slave)
  );

  int total = 0;
  int bad = 0;
  int frame_no = 0;
  int div = 0;

  int fe_cnt = 0;
  int ov_cnt = 0;
  int wide_cnt = 0;
  logic fe_prev = 1'b0;
  logic ov_prev = 1'b0;

  logic       exp_ready = 1'b0;
  logic [7:0] exp_data = 8'h00;
  logic       exp_perr = 1'b0;
  int         exp_fe = 0;
  int         exp_ov = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    baud_clock = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      baud_clock = (div == 3);
      div = (div + 1) % 4;
    end
  end

  always @(posedge clk) begin
    #1;
    if (u_if.framing_err) begin
      fe_cnt++;
      if (fe_prev) wide_cnt++;
    end
    if (u_if.overflow) begin
      ov_cnt++;
      if (ov_prev) wide_cnt++;
    end
    fe_prev = u_if.framing_err;
    ov_prev = u_if.overflow;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s frame=%0d got=0x%0h exp=0x%0h", tag, frame_no, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!baud_clock) @(posedge clk);
    end
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx_in = v;
    wait_ticks(16);
  endtask

  task automatic host_read();
    @(posedge clk);
    #1 u_if.read_rx_byte = 1'b1;
    @(posedge clk);
    #1 u_if.read_rx_byte = 1'b0;
    exp_ready = 1'b0;
    exp_perr  = 1'b0;
  endtask

  task automatic check_outputs();
    check("rx_ready", {31'd0, u_if.rx_ready}, {31'd0, exp_ready});
    check("rx_data", {24'd0, u_if.rx_data}, {24'd0, exp_data});
    check("parity_err", {31'd0, u_if.parity_err}, {31'd0, exp_perr});
    check("framing_pulses", fe_cnt, exp_fe);
    check("overflow_pulses", ov_cnt, exp_ov);
  endtask

  // One complete frame; the model is updated from the frame contents alone.
  task automatic send_frame(input logic [7:0] d, input logic b8, input logic pen,
                            input logic odd, input logic pbit_ok, input logic stop_v,
                            input logic rd_at_sp);
    logic [7:0] m;
    int         ones;
    int         nb;
    logic       pbit;
    logic       perr;
    frame_no++;
    bit8       = b8;
    parity_en  = pen;
    odd_n_even = odd;
    m    = b8 ? 8'hff : 8'h7f;
    nb   = b8 ? 8 : 7;
    ones = $countones(d & m);
    pbit = ((ones % 2) == 1) ? ~odd : odd;
    if (!pbit_ok) pbit = ~pbit;
    perr = pen && (((ones + (pbit ? 1 : 0)) % 2) != (odd ? 1 : 0));

    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) drive_bit(d[i]);
    if (pen) drive_bit(pbit);
    rx_in = stop_v;
    if (rd_at_sp) begin
      wait_ticks(SP + 1);
      do begin
        @(posedge clk);
        #3;
      end while (!baud_clock);
      u_if.read_rx_byte = 1'b1;
      @(posedge clk);
      #1 u_if.read_rx_byte = 1'b0;
      wait_ticks(16 - SP - 2);
    end else begin
      wait_ticks(16);
    end
    rx_in = 1'b1;
    wait_ticks(20);

    if (rd_at_sp || !exp_ready) begin
      exp_data  = d & m;
      exp_perr  = perr;
      exp_ready = 1'b1;
    end else begin
      exp_ov++;
    end
    if (!stop_v) exp_fe++;
  endtask

  initial begin
    reset_n           = 1'b0;
    rx_in             = 1'b1;
    bit8              = 1'b1;
    parity_en         = 1'b0;
    odd_n_even        = 1'b0;
    u_if.read_rx_byte = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_outputs();
    reset_n = 1'b1;
    wait_ticks(4);

    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_outputs();
    host_read();
    check_outputs();

    send_frame(8'h41, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check_outputs();
    host_read();
    send_frame(8'h41, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check_outputs();
    host_read();

    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_outputs();
    host_read();

    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_outputs();
    send_frame(8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check_outputs();
    host_read();

    frame_no++;
    rx_in = 1'b0;
    wait_ticks(4);
    rx_in = 1'b1;
    wait_ticks(30);
    check_outputs();
    send_frame(8'h66, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_outputs();

    frame_no++;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    wait_ticks(5);
    reset_n = 1'b0;
    exp_ready = 1'b0;
    exp_data  = 8'h00;
    exp_perr  = 1'b0;
    @(posedge clk);
    #1;
    check_outputs();
    rx_in = 1'b1;
    wait_ticks(3);
    reset_n = 1'b1;
    wait_ticks(20);
    check_outputs();
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_outputs();

    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 1) == 1) host_read();
      send_frame(8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 5) != 0),
                 ($urandom_range(0, 3) == 0));
      check_outputs();
    end

    check("pulse_width", wide_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
